// File: rtl/dncntr_timer_pkg.sv
// dncntr_timer_pkg: shared state encoding and default parameters for the down-counting timer.
package dncntr_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESCALE = 1;

endpackage

// File: rtl/dncntr_tick.sv
// dncntr_tick: prescaler producing one tick every PRESCALE enabled cycles.
module dncntr_tick
    import dncntr_timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clock,
    input  logic start_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;

    // With PRESCALE=1 cnt is pinned at 0, so tick reduces to enable.
    assign tick = enable && (cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clock or negedge start_n) begin
        if (!start_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/dncntr_timer.sv
// dncntr_timer: loadable down-counter with prescaled ticks, done pulse and optional auto-reload.
module dncntr_timer
    import dncntr_timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clock,
    input  logic             start_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_nxt, rld, rld_nxt;
    logic             done_nxt, clr, tick;

    assign load_ready = (state == ST_IDLE);
    assign busy       = (state == ST_RUN);

    dncntr_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clock   (clock),
        .start_n (start_n),
        .clear   (clr),
        .enable  (enable && busy),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        rld_nxt   = rld;
        done_nxt  = 1'b0;
        clr       = 1'b0;
        if (state == ST_IDLE) begin
            if (load_valid) begin
                data_nxt  = load_value;
                rld_nxt   = load_value;
                clr       = 1'b1;
                state_nxt = (load_value != '0) ? ST_RUN : ST_IDLE;
                done_nxt  = (load_value == '0);
            end
        end else if (abort) begin
            state_nxt = ST_IDLE;
            data_nxt  = '0;
            clr       = 1'b1;
        end else if (tick) begin
            // data is always >=1 in RUN, so the else branch is the expiry.
            if (data > WIDTH'(1)) begin
                data_nxt = data - WIDTH'(1);
            end else begin
                done_nxt  = 1'b1;
                data_nxt  = auto_reload ? rld : '0;
                state_nxt = auto_reload ? ST_RUN : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge start_n) begin
        if (!start_n) begin
            state <= ST_IDLE;
            data  <= '0;
            rld   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            rld   <= rld_nxt;
            done  <= done_nxt;
        end
    end

endmodule
